// File: rtl/uart_tx_sched_if.sv
// Handshake and line bundle between the two byte requesters and the shared UART transmitter.
// The transmitter connects through the slave modport, and the requester side connects through the master modport.
interface uart_tx_sched_if;
    logic       req0;
    logic [7:0] data0;
    logic       ack0;
    logic       req1;
    logic [7:0] data1;
    logic       ack1;
    logic       tx;
    logic       busy;
    logic       gnt_id;
    logic       frame_done;

    modport master (
        output req0, data0, req1, data1,
        input  ack0, ack1, tx, busy, gnt_id, frame_done
    );

    modport slave (
        input  req0, data0, req1, data1,
        output ack0, ack1, tx, busy, gnt_id, frame_done
    );
endinterface

// File: rtl/uart_tx_sched.sv
// Shares one UART transmitter between two byte requesters. Each frame is {stop,stop,data,even parity,start}, sent LSB first.
// Defining UART_TX_FIXED_PRIO_EN makes requester 0 win every contention; the default build uses round-robin.
module uart_tx_sched #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int GAP_BITS     = 1
) (
    input  logic           clk,
    input  logic           rst,
    uart_tx_sched_if.slave bus
);
    localparam int               CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       BIT_LAST = 4'd11;
    localparam logic [3:0]       GAP_LAST = (GAP_BITS > 0) ? 4'(GAP_BITS - 1) : 4'd0;

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;

    state_t           r_state,   w_state_nxt;
    logic [CNT_W-1:0] r_clk_cnt, w_clk_cnt_nxt;
    logic [3:0]       r_bit_cnt, w_bit_cnt_nxt;
    logic [10:0]      r_shreg,   w_shreg_nxt;
    logic             r_tx,      w_tx_nxt;
    logic             r_busy,    w_busy_nxt;
    logic             r_gnt_id,  w_gnt_id_nxt;
    logic             r_rr_last, w_rr_last_nxt;
    logic             r_ack0,    w_ack0_nxt;
    logic             r_ack1,    w_ack1_nxt;
    logic             r_done,    w_done_nxt;
    logic             w_winner;
    logic [7:0]       w_data;

    always_comb begin
`ifdef UART_TX_FIXED_PRIO_EN
        w_winner = !bus.req0;
`else
        if (bus.req0 && bus.req1) begin
            w_winner = !r_rr_last;
        end else begin
            w_winner = !bus.req0;
        end
`endif
        w_data = w_winner ? bus.data1 : bus.data0;
    end

    // The shift register holds frame bits 1..11; the start bit goes straight to tx at grant time.
    always_comb begin
        // NOTE: every next-state signal is assigned a default value first, so no latch can be inferred.
        w_state_nxt   = r_state;
        w_clk_cnt_nxt = r_clk_cnt;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shreg_nxt   = r_shreg;
        w_tx_nxt      = r_tx;
        w_busy_nxt    = r_busy;
        w_gnt_id_nxt  = r_gnt_id;
        w_rr_last_nxt = r_rr_last;
        w_ack0_nxt    = 1'b0;
        w_ack1_nxt    = 1'b0;
        w_done_nxt    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.req0 || bus.req1) begin
                    w_shreg_nxt   = {2'b11, w_data, ^w_data};
                    w_tx_nxt      = 1'b0;
                    w_ack0_nxt    = !w_winner;
                    w_ack1_nxt    = w_winner;
                    w_gnt_id_nxt  = w_winner;
                    w_rr_last_nxt = w_winner;
                    w_busy_nxt    = 1'b1;
                    w_clk_cnt_nxt = '0;
                    w_bit_cnt_nxt = '0;
                    w_state_nxt   = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (r_clk_cnt == CNT_LAST) begin
                    w_clk_cnt_nxt = '0;
                    if (r_bit_cnt == BIT_LAST) begin
                        w_bit_cnt_nxt = '0;
                        w_tx_nxt      = 1'b1;
                        w_done_nxt    = 1'b1;
                        if (GAP_BITS == 0) begin
                            w_busy_nxt  = 1'b0;
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_state_nxt = ST_GAP;
                        end
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                        w_tx_nxt      = r_shreg[0];
                        w_shreg_nxt   = {1'b1, r_shreg[10:1]};
                    end
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + 1'b1;
                end
            end

            ST_GAP: begin
                if (r_clk_cnt == CNT_LAST) begin
                    w_clk_cnt_nxt = '0;
                    if (r_bit_cnt == GAP_LAST) begin
                        w_bit_cnt_nxt = '0;
                        w_busy_nxt    = 1'b0;
                        w_state_nxt   = ST_IDLE;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    end
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + 1'b1;
                end
            end

            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: the state registers use non-blocking assignments, so every flop samples the values from before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_shreg   <= '1;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_gnt_id  <= 1'b0;
            r_rr_last <= 1'b1;
            r_ack0    <= 1'b0;
            r_ack1    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_clk_cnt <= w_clk_cnt_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_shreg   <= w_shreg_nxt;
            r_tx      <= w_tx_nxt;
            r_busy    <= w_busy_nxt;
            r_gnt_id  <= w_gnt_id_nxt;
            r_rr_last <= w_rr_last_nxt;
            r_ack0    <= w_ack0_nxt;
            r_ack1    <= w_ack1_nxt;
            r_done    <= w_done_nxt;
        end
    end

    assign bus.tx         = r_tx;
    assign bus.busy       = r_busy;
    assign bus.gnt_id     = r_gnt_id;
    assign bus.ack0       = r_ack0;
    assign bus.ack1       = r_ack1;
    assign bus.frame_done = r_done;
endmodule
